locked_reg_bank: RTL and testbench
==================================

// Module: locked_reg_bank
// PURPOSE
//  Bank of NUM_REGS lockable configuration registers, each WIDTH bits, for security-sensitive settings.
//  Each register has a sticky lock bit that only resetn can clear.
//  A locked register can be written only through an armed debug window: debug_mode & trusted & correct key.
//  Rejected writes are reported with an error response and counted in a saturating violation counter.
// PARAMETERS
//  WIDTH       16        data width of each register
//  NUM_REGS    4         number of registers (>=2); AW = $clog2(NUM_REGS)
//  DBG_KEY     16'hA5C3  key that arms a debug window (WIDTH bits)
//  DBG_WINDOW  8         cycles an armed window stays open (>=1)
//  CNT_W       8         violation counter width
// PORTS
//  Clk            in   1              clock, rising edge
//  resetn         in   1              asynchronous active-low reset
//  wr_valid       in   1              write request valid
//  wr_ready       out  1              write request accepted when wr_valid & wr_ready
//  wr_addr        in   AW             write register index
//  wr_data        in   WIDTH          write data
//  wr_resp_valid  out  1              write response valid
//  wr_resp_ready  in   1              response consumed
//  wr_resp_err    out  1              1 = write rejected (locked, bad address)
//  lock_req       in   1              set lock bit of register lock_addr
//  lock_addr      in   AW             register index to lock
//  lock_all       in   1              set every lock bit
//  rd_addr        in   AW             read index
//  rd_data        out  WIDTH          registered read data, 1-cycle latency; 0 for out-of-range index
//  lock_status    out  NUM_REGS       current lock bits
//  debug_mode     in   1              debug mode
//  trusted        in   1              trusted-agent qualifier
//  dbg_key_valid  in   1              dbg_key is presented this cycle
//  dbg_key        in   WIDTH          arming key
//  dbg_armed      out  1              debug window open
//  violation_cnt  out  CNT_W          saturating count of rejected writes and bad keys
// BEHAVIOUR
//  Reset: regs=0, lock_status=0, rd_data=0, wr_resp_valid=0, wr_resp_err=0, dbg FSM=IDLE, dbg_armed=0, violation_cnt=0.
//  Write handshake
//   - wr_ready = ~wr_resp_valid | wr_resp_ready (single response slot).
//   - Accepted write: register updates at the same edge; response valid the next cycle.
//   - Response is held until wr_resp_ready.
//  Write decision for register i (accept cycle)
//   - addr >= NUM_REGS: err=1, no update.
//   - eff_lock[i] = lock_status[i] | (lock_req & lock_addr==i) | lock_all; a same-cycle lock wins.
//   - ~eff_lock[i]: update, err=0.
//   - eff_lock[i] & FSM==ARMED & debug_mode & trusted: update, err=0, FSM->IDLE (one write per window).
//   - Otherwise: err=1, no update.
//  Locks: lock bits are sticky. Set by lock_req/lock_all at the edge; never cleared except by resetn.
//  Debug FSM (2 states)
//   - IDLE -> ARMED on dbg_key_valid & debug_mode & trusted & dbg_key==DBG_KEY; window counter loads DBG_WINDOW-1.
//   - IDLE, dbg_key_valid & key mismatch (or ~debug_mode | ~trusted): stay IDLE, violation++.
//   - ARMED -> IDLE on any of:
//       counter==0 at the edge;
//       ~debug_mode | ~trusted, same edge;
//       a debug write consumed;
//       dbg_key_valid with a wrong key (violation++).
//     A correct key while ARMED reloads the counter.
//   - dbg_armed = (FSM==ARMED).
//  violation_cnt: +1 per rejected write or bad key. Two events in one cycle add 2. Saturates at 2^CNT_W-1, never wraps.
//  Reset mid-operation: pending response dropped, window closed, locks cleared. Asynchronous.
//  rd_data: registered mux of regs[rd_addr]; reflects writes from the previous edge.
// STRUCTURE
//  Package locked_reg_pkg: dbg_state_t {DBG_IDLE, DBG_ARMED}, RESP_OK/RESP_ERR constants.
//  Sub-module locked_reg_dbg_fsm: key compare, window counter, armed/consume interface.
//  Top: register array, lock vector, response slot, violation counter.
// TESTING
//  1. Reset; write addr1=16'h1234 -> resp err=0, rd addr1 = 16'h1234 next cycle.
//  2. lock_req addr1; write 16'hBEEF -> err=1, reg stays 16'h1234, violation_cnt=1.
//  3. Write addr2 with lock_all in the same cycle -> err=1, reg2 unchanged, lock_status=4'hF.
//  4. debug_mode=trusted=1, key 16'hA5C3, locked write 16'h5555 at cycle 3 -> err=0, reg=16'h5555, dbg_armed=0.
//     A second write -> err=1.
//  5. Arm, then idle DBG_WINDOW cycles -> dbg_armed=0; next locked write err=1.
//     Arm, drop trusted -> disarmed the next cycle.
//  6. Wrong key x300 with CNT_W=8 -> violation_cnt saturates at 255.
//     Assert resetn mid-response -> all outputs 0, locks clear.

Source files
------------

// File: rtl/locked_reg_pkg.sv
// Shared types and constants for the lockable configuration register bank.
package locked_reg_pkg;

    typedef enum logic {
        DBG_IDLE  = 1'b0,
        DBG_ARMED = 1'b1
    } dbg_state_t;

    localparam logic RESP_OK  = 1'b0;
    localparam logic RESP_ERR = 1'b1;

endpackage

// File: rtl/locked_reg_dbg_fsm.sv
// Debug window controller: key check, window countdown, single-use consume.
module locked_reg_dbg_fsm
    import locked_reg_pkg::*;
#(
    parameter int unsigned      WIDTH      = 16,
    parameter logic [WIDTH-1:0] DBG_KEY    = 16'hA5C3,
    parameter int unsigned      DBG_WINDOW = 8
) (
    input  logic             Clk,
    input  logic             resetn,
    input  logic             debug_mode,
    input  logic             trusted,
    input  logic             dbg_key_valid,
    input  logic [WIDTH-1:0] dbg_key,
    input  logic             consume,
    output logic             armed,
    output logic             bad_key
);

    localparam int unsigned    CW   = (DBG_WINDOW > 1) ? $clog2(DBG_WINDOW) : 1;
    localparam logic [CW-1:0]  LOAD = CW'(DBG_WINDOW - 1);

    dbg_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          qualified;
    logic          key_hit;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        qualified = debug_mode & trusted;
        key_hit   = dbg_key_valid & qualified & (dbg_key == DBG_KEY);
        bad_key   = dbg_key_valid & ~key_hit;
        unique case (state_q)
            DBG_IDLE: begin
                if (key_hit) begin
                    state_d = DBG_ARMED;
                    cnt_d   = LOAD;
                end
            end
            DBG_ARMED: begin
                // Any loss of qualification, a used write or a bad key closes the window.
                if (~qualified | consume | bad_key) begin
                    state_d = DBG_IDLE;
                end else if (key_hit) begin
                    cnt_d = LOAD;
                end else if (cnt_q == '0) begin
                    state_d = DBG_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= DBG_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign armed = (state_q == DBG_ARMED);

endmodule

// File: rtl/locked_reg_bank.sv
// Lockable configuration register bank with debug-window override and violation counting.
module locked_reg_bank
    import locked_reg_pkg::*;
#(
    parameter int unsigned      WIDTH      = 16,
    parameter int unsigned      NUM_REGS   = 4,
    parameter logic [WIDTH-1:0] DBG_KEY    = 16'hA5C3,
    parameter int unsigned      DBG_WINDOW = 8,
    parameter int unsigned      CNT_W      = 8,
    localparam int unsigned     AW         = $clog2(NUM_REGS)
) (
    input  logic                Clk,
    input  logic                resetn,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [AW-1:0]       wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    output logic                wr_resp_valid,
    input  logic                wr_resp_ready,
    output logic                wr_resp_err,
    input  logic                lock_req,
    input  logic [AW-1:0]       lock_addr,
    input  logic                lock_all,
    input  logic [AW-1:0]       rd_addr,
    output logic [WIDTH-1:0]    rd_data,
    output logic [NUM_REGS-1:0] lock_status,
    input  logic                debug_mode,
    input  logic                trusted,
    input  logic                dbg_key_valid,
    input  logic [WIDTH-1:0]    dbg_key,
    output logic                dbg_armed,
    output logic [CNT_W-1:0]    violation_cnt
);

    localparam logic [AW:0]      NUM_REGS_W = (AW + 1)'(NUM_REGS);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    logic [WIDTH-1:0]    regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] lock_q, lock_d, lock_set;
    logic                resp_valid_q, resp_err_q;
    logic [WIDTH-1:0]    rd_data_q, rd_next;
    logic [CNT_W-1:0]    viol_q, viol_d;
    logic [CNT_W+1:0]    viol_sum;

    logic accept, addr_ok, eff_lock, dbg_ok, wr_update, wr_reject, consume, bad_key;

    assign wr_ready = ~resp_valid_q | wr_resp_ready;
    assign accept   = wr_valid & wr_ready;
    assign addr_ok  = {1'b0, wr_addr} < NUM_REGS_W;

    // Same-cycle lock requests are folded in so a racing lock always wins.
    always_comb begin
        lock_set = '0;
        eff_lock = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            lock_set[i] = lock_all | (lock_req & (lock_addr == AW'(i)));
            if (wr_addr == AW'(i)) begin
                eff_lock = lock_q[i] | lock_set[i];
            end
        end
        lock_d = lock_q | lock_set;
    end

    assign dbg_ok    = dbg_armed & debug_mode & trusted;
    assign consume   = accept & addr_ok & eff_lock & dbg_ok;
    assign wr_update = accept & addr_ok & (~eff_lock | dbg_ok);
    assign wr_reject = accept & ~wr_update;

    locked_reg_dbg_fsm #(
        .WIDTH      (WIDTH),
        .DBG_KEY    (DBG_KEY),
        .DBG_WINDOW (DBG_WINDOW)
    ) u_dbg_fsm (
        .Clk           (Clk),
        .resetn        (resetn),
        .debug_mode    (debug_mode),
        .trusted       (trusted),
        .dbg_key_valid (dbg_key_valid),
        .dbg_key       (dbg_key),
        .consume       (consume),
        .armed         (dbg_armed),
        .bad_key       (bad_key)
    );

    // Widened sum lets a double event at CNT_MAX-1 saturate instead of wrapping.
    always_comb begin
        viol_sum = {2'b00, viol_q} + (CNT_W + 2)'(wr_reject) + (CNT_W + 2)'(bad_key);
        if (viol_sum > {2'b00, CNT_MAX}) begin
            viol_d = CNT_MAX;
        end else begin
            viol_d = viol_sum[CNT_W-1:0];
        end
    end

    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == AW'(i)) begin
                rd_next = regs_q[i];
            end
        end
    end

    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_update) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_addr == AW'(i)) begin
                    regs_q[i] <= wr_data;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            lock_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= RESP_OK;
            rd_data_q    <= '0;
            viol_q       <= '0;
        end else begin
            lock_q    <= lock_d;
            rd_data_q <= rd_next;
            viol_q    <= viol_d;
            if (accept) begin
                resp_valid_q <= 1'b1;
                resp_err_q   <= wr_reject ? RESP_ERR : RESP_OK;
            end else if (wr_resp_ready) begin
                resp_valid_q <= 1'b0;
                resp_err_q   <= RESP_OK;
            end
        end
    end

    assign wr_resp_valid = resp_valid_q;
    assign wr_resp_err   = resp_err_q;
    assign lock_status   = lock_q;
    assign rd_data       = rd_data_q;
    assign violation_cnt = viol_q;

endmodule

// File: tb/tb_locked_reg_bank.sv
// Directed self-checking bench for locked_reg_bank.
module tb_locked_reg_bank;

    logic        Clk = 1'b0;
    logic        resetn;
    logic        wr_valid, wr_ready;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_resp_valid, wr_resp_ready, wr_resp_err;
    logic        lock_req, lock_all;
    logic [1:0]  lock_addr, rd_addr;
    logic [15:0] rd_data;
    logic [3:0]  lock_status;
    logic        debug_mode, trusted, dbg_key_valid, dbg_armed;
    logic [15:0] dbg_key;
    logic [7:0]  violation_cnt;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    locked_reg_bank dut (
        .Clk           (Clk),
        .resetn        (resetn),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_resp_valid (wr_resp_valid),
        .wr_resp_ready (wr_resp_ready),
        .wr_resp_err   (wr_resp_err),
        .lock_req      (lock_req),
        .lock_addr     (lock_addr),
        .lock_all      (lock_all),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .lock_status   (lock_status),
        .debug_mode    (debug_mode),
        .trusted       (trusted),
        .dbg_key_valid (dbg_key_valid),
        .dbg_key       (dbg_key),
        .dbg_armed     (dbg_armed),
        .violation_cnt (violation_cnt)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic write(input logic [1:0] a, input logic [15:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic read(input logic [1:0] a);
        rd_addr = a;
        tick();
    endtask

    task automatic arm();
        dbg_key_valid = 1'b1;
        dbg_key       = 16'hA5C3;
        tick();
        dbg_key_valid = 1'b0;
    endtask

    task automatic test_reset();
        wr_valid = 0; wr_addr = 0; wr_data = 0; wr_resp_ready = 1;
        lock_req = 0; lock_addr = 0; lock_all = 0; rd_addr = 0;
        debug_mode = 0; trusted = 0; dbg_key_valid = 0; dbg_key = 0;
        resetn = 0;
        #12;
        resetn = 1;
        #1;
        checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 0000", rd_data); end
        checks++; if ({wr_resp_valid, wr_resp_err, dbg_armed} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {wr_resp_valid, wr_resp_err, dbg_armed}); end
        checks++; if (lock_status !== 4'h0 || violation_cnt !== 8'd0) begin errors++; $display("FAIL reset_lock_cnt got %h/%0d exp 0/0", lock_status, violation_cnt); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready); end
    endtask

    task automatic test_basic_write();
        write(2'd1, 16'h1234);
        checks++; if (wr_resp_valid !== 1'b1 || wr_resp_err !== 1'b0) begin errors++; $display("FAIL basic_resp got v=%b e=%b exp v=1 e=0", wr_resp_valid, wr_resp_err); end
        read(2'd1);
        checks++; if (rd_data !== 16'h1234) begin errors++; $display("FAIL basic_read got %h exp 1234", rd_data); end
    endtask

    task automatic test_lock_single();
        lock_req = 1; lock_addr = 2'd1;
        tick();
        lock_req = 0;
        checks++; if (lock_status !== 4'b0010) begin errors++; $display("FAIL lock1_status got %b exp 0010", lock_status); end
        write(2'd1, 16'hBEEF);
        checks++; if (wr_resp_err !== 1'b1) begin errors++; $display("FAIL lock1_err got %b exp 1", wr_resp_err); end
        checks++; if (violation_cnt !== 8'd1) begin errors++; $display("FAIL lock1_viol got %0d exp 1", violation_cnt); end
        read(2'd1);
        checks++; if (rd_data !== 16'h1234) begin errors++; $display("FAIL lock1_keep got %h exp 1234", rd_data); end
    endtask

    task automatic test_lock_race();
        lock_all = 1;
        write(2'd2, 16'h7777);
        lock_all = 0;
        checks++; if (wr_resp_err !== 1'b1) begin errors++; $display("FAIL race_err got %b exp 1", wr_resp_err); end
        checks++; if (lock_status !== 4'hF) begin errors++; $display("FAIL race_status got %h exp F", lock_status); end
        read(2'd2);
        checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL race_reg2 got %h exp 0000", rd_data); end
        checks++; if (violation_cnt !== 8'd2) begin errors++; $display("FAIL race_viol got %0d exp 2", violation_cnt); end
    endtask

    task automatic test_debug_write();
        debug_mode = 1; trusted = 1;
        arm();
        checks++; if (dbg_armed !== 1'b1) begin errors++; $display("FAIL dbg_armed got %b exp 1", dbg_armed); end
        tick();
        write(2'd1, 16'h5555);
        checks++; if (wr_resp_err !== 1'b0 || dbg_armed !== 1'b0) begin errors++; $display("FAIL dbg_write got e=%b a=%b exp e=0 a=0", wr_resp_err, dbg_armed); end
        read(2'd1);
        checks++; if (rd_data !== 16'h5555) begin errors++; $display("FAIL dbg_reg got %h exp 5555", rd_data); end
        write(2'd1, 16'h1111);
        checks++; if (wr_resp_err !== 1'b1 || violation_cnt !== 8'd3) begin errors++; $display("FAIL dbg_second got e=%b v=%0d exp e=1 v=3", wr_resp_err, violation_cnt); end
    endtask

    task automatic test_window_expiry();
        arm();
        repeat (7) tick();
        checks++; if (dbg_armed !== 1'b1) begin errors++; $display("FAIL win_last_cycle got %b exp 1", dbg_armed); end
        tick();
        checks++; if (dbg_armed !== 1'b0) begin errors++; $display("FAIL win_expired got %b exp 0", dbg_armed); end
        write(2'd3, 16'hABCD);
        checks++; if (wr_resp_err !== 1'b1 || violation_cnt !== 8'd4) begin errors++; $display("FAIL win_write got e=%b v=%0d exp e=1 v=4", wr_resp_err, violation_cnt); end
        arm();
        trusted = 0;
        tick();
        checks++; if (dbg_armed !== 1'b0) begin errors++; $display("FAIL untrusted_close got %b exp 0", dbg_armed); end
        trusted = 1;
    endtask

    task automatic test_double_event();
        dbg_key_valid = 1; dbg_key = 16'h1111;
        write(2'd0, 16'h2222);
        dbg_key_valid = 0;
        checks++; if (violation_cnt !== 8'd6) begin errors++; $display("FAIL double_viol got %0d exp 6", violation_cnt); end
    endtask

    task automatic test_saturation();
        dbg_key_valid = 1; dbg_key = 16'h0BAD;
        repeat (248) tick();
        checks++; if (violation_cnt !== 8'd254) begin errors++; $display("FAIL sat_pre got %0d exp 254", violation_cnt); end
        repeat (52) tick();
        dbg_key_valid = 0;
        checks++; if (violation_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d exp 255", violation_cnt); end
    endtask

    task automatic test_reset_mid();
        wr_resp_ready = 0;
        write(2'd0, 16'h3333);
        tick();
        checks++; if (wr_resp_valid !== 1'b1 || wr_ready !== 1'b0) begin errors++; $display("FAIL hold_resp got v=%b r=%b exp v=1 r=0", wr_resp_valid, wr_ready); end
        arm();
        read(2'd1);
        #2;
        resetn = 0;
        #1;
        checks++; if ({wr_resp_valid, wr_resp_err, dbg_armed} !== 3'b000 || rd_data !== 16'h0) begin errors++; $display("FAIL async_flags got %b rd=%h exp 000 rd=0000", {wr_resp_valid, wr_resp_err, dbg_armed}, rd_data); end
        checks++; if (lock_status !== 4'h0 || violation_cnt !== 8'd0) begin errors++; $display("FAIL async_lock_cnt got %h/%0d exp 0/0", lock_status, violation_cnt); end
        #3;
        resetn = 1;
        wr_resp_ready = 1;
        read(2'd1);
        checks++; if (rd_data !== 16'h0000 || wr_ready !== 1'b1) begin errors++; $display("FAIL post_reset got rd=%h r=%b exp 0000/1", rd_data, wr_ready); end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_lock_single();
        test_lock_race();
        test_debug_write();
        test_window_expiry();
        test_double_event();
        test_saturation();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
